// File: rtl/hack_memory_pkg.sv
// Shared definitions for the Hack data-memory block.
//   - word width and region bases/sizes of the CPU address map
//   - clear-engine FSM state encoding
//   - address-decode helpers used by the top level
package hack_memory_pkg;

    localparam int WORD_W = 16;

    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] SCREEN_BASE = 16'h4000;
    localparam logic [15:0] KBD_ADDR    = 16'h6000;

    localparam int RAM_WORDS    = 16384;
    localparam int SCREEN_WORDS = 8192;
    localparam int RAM_AW       = 14;
    localparam int SCREEN_AW    = 13;

    localparam logic [SCREEN_AW-1:0] SCREEN_LAST = 13'h1FFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // RAM occupies the lower quarter of the map: only the top two bits decode.
    function automatic logic in_ram(input logic [15:0] a);
        return a[15:14] == RAM_BASE[15:14];
    endfunction

    // SCREEN is an 8K-word window: the top three bits decode.
    function automatic logic in_screen(input logic [15:0] a);
        return a[15:13] == SCREEN_BASE[15:13];
    endfunction

endpackage

// File: rtl/hack_ram.sv
// Single-port-write word memory used for both RAM and SCREEN.
//   clk_i       clock; writes commit on the rising edge
//   rst_ni      async active-low reset (clears only the second read register)
//   we_i        write enable
//   waddr_i     write address
//   wdata_i     write data
//   raddr_i     asynchronous read address
//   rdata_o     asynchronous read data
//   rd2_addr_i  second read port address (used when RD2_EN=1)
//   rd2_data_o  registered second read data, 1-cycle latency, old data on
//               a same-cycle write to the same word
module hack_ram
    import hack_memory_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit RD2_EN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] rd2_addr_i,
    output logic [WORD_W-1:0] rd2_data_o
);

    // Contents are deliberately not reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    generate
        if (RD2_EN) begin : g_rd2
            logic [WORD_W-1:0] rd2_q;
            // Non-blocking sample of the array yields the pre-write word.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rd2_q <= '0;
                end else begin
                    rd2_q <= mem_q[rd2_addr_i];
                end
            end
            assign rd2_data_o = rd2_q;
        end else begin : g_no_rd2
            logic unused_rd2;
            assign unused_rd2 = ^{rd2_addr_i, rst_ni};
            assign rd2_data_o = '0;
        end
    endgenerate

endmodule

// File: rtl/hack_memory.sv
// Hack computer data memory: RAM, memory-mapped SCREEN and KBD register,
// a registered display scan port and a hardware screen-clear engine.
//   clk          clock
//   reset_n      async active-low reset (control state, KBD, disp_data)
//   addressM     CPU address; outM / writeM CPU write data / enable
//   inM          combinational read data for addressM (0 when unmapped)
//   kbd_strobe   loads kbd_code into the KBD register
//   kbd_code     key code, 0 = no key
//   disp_addr    display scan word address; disp_data registered word
//   clear_start  request a full-screen clear; clear_busy while running
module hack_memory
    import hack_memory_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        kbd_strobe,
    input  logic [15:0] kbd_code,
    input  logic [12:0] disp_addr,
    output logic [15:0] disp_data,
    input  logic        clear_start,
    output logic        clear_busy
);

    logic ram_sel, scr_sel, kbd_sel;
    logic ram_we, cpu_scr_we;

    assign ram_sel    = in_ram(addressM);
    assign scr_sel    = in_screen(addressM);
    assign kbd_sel    = (addressM == KBD_ADDR);
    assign ram_we     = writeM & ram_sel;
    assign cpu_scr_we = writeM & scr_sel;

    // KBD register: holds the last strobed code, including 0 on release.
    logic [15:0] kbd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kbd_q <= '0;
        end else if (kbd_strobe) begin
            kbd_q <= kbd_code;
        end
    end

    // Clear engine
    clr_state_e             state_q, state_d;
    logic [SCREEN_AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic                   clr_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                // A CPU write to SCREEN owns the write port this cycle;
                // the engine simply waits without advancing.
                if (!cpu_scr_we) begin
                    clr_we    = 1'b1;
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == SCREEN_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clear_busy = (state_q == ST_CLEAR);

    // SCREEN write port shared between the CPU and the clear engine.
    logic                 scr_we;
    logic [SCREEN_AW-1:0] scr_waddr;
    logic [15:0]          scr_wdata;

    assign scr_we    = cpu_scr_we | clr_we;
    assign scr_waddr = cpu_scr_we ? addressM[SCREEN_AW-1:0] : clr_ptr_q;
    assign scr_wdata = cpu_scr_we ? outM : 16'h0000;

    logic [15:0] ram_rdata, scr_rdata, ram_unused_rd2;

    hack_ram #(
        .DEPTH  (RAM_WORDS),
        .ADDR_W (RAM_AW),
        .RD2_EN (1'b0)
    ) u_ram (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .we_i       (ram_we),
        .waddr_i    (addressM[RAM_AW-1:0]),
        .wdata_i    (outM),
        .raddr_i    (addressM[RAM_AW-1:0]),
        .rdata_o    (ram_rdata),
        .rd2_addr_i ('0),
        .rd2_data_o (ram_unused_rd2)
    );

    hack_ram #(
        .DEPTH  (SCREEN_WORDS),
        .ADDR_W (SCREEN_AW),
        .RD2_EN (1'b1)
    ) u_screen (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .we_i       (scr_we),
        .waddr_i    (scr_waddr),
        .wdata_i    (scr_wdata),
        .raddr_i    (addressM[SCREEN_AW-1:0]),
        .rdata_o    (scr_rdata),
        .rd2_addr_i (disp_addr),
        .rd2_data_o (disp_data)
    );

    always_comb begin
        inM = 16'h0000;
        if (ram_sel) begin
            inM = ram_rdata;
        end else if (scr_sel) begin
            inM = scr_rdata;
        end else if (kbd_sel) begin
            inM = kbd_q;
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
`timescale 1ns/1ps
module tb_hack_memory;

    localparam int K_INM  = 0;
    localparam int K_DISP = 1;
    localparam int K_BUSY = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addressM, outM, inM, kbd_code, disp_data;
    logic        writeM, kbd_strobe, clear_start, clear_busy;
    logic [12:0] disp_addr;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    hack_memory dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addressM    (addressM),
        .outM        (outM),
        .writeM      (writeM),
        .inM         (inM),
        .kbd_strobe  (kbd_strobe),
        .kbd_code    (kbd_code),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .clear_start (clear_start),
        .clear_busy  (clear_busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expected value for the signal as seen at the coming falling edge.
    function automatic void sb_push(input string name, input int kind,
                                    input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endfunction

    // Monitor: samples the DUT on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_INM:   act = inM;
                K_DISP:  act = disp_data;
                default: act = {15'b0, clear_busy};
            endcase
            check(e.name, {16'b0, act}, {16'b0, e.exp});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        step();
        writeM   = 1'b0;
    endtask

    task automatic fill_screen(input logic [15:0] d);
        for (int i = 0; i < 8192; i++) begin
            cpu_write(16'(16'h4000 + i), d);
        end
    endtask

    task automatic scan_screen(input int lo, input int hi, input logic [15:0] d,
                               input string name);
        writeM = 1'b0;
        for (int i = lo; i <= hi; i++) begin
            addressM = 16'(16'h4000 + i);
            sb_push(name, K_INM, d);
            step();
        end
    endtask

    // Runs a clear and returns the number of cycles clear_busy stayed high.
    // stall_at >= 0 injects a CPU SCREEN write of 0x5555 to 0x4000 when the
    // pointer equals stall_at; a RAM write and a second clear_start are
    // injected at fixed points to show neither disturbs the engine.
    task automatic run_clear(input int stall_at, output int len);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        len = 0;
        while (clear_busy === 1'b1 && len < 9000) begin
            if (len == 10) clear_start = 1'b1;
            if (len == 20) begin
                addressM = 16'h0100;
                outM     = 16'h4242;
                writeM   = 1'b1;
            end
            if (stall_at >= 0 && len == stall_at) begin
                addressM = 16'h4000;
                outM     = 16'h5555;
                writeM   = 1'b1;
                sb_push("clr_word0_before_cpu_wr", K_INM, 16'h0000);
            end
            step();
            writeM      = 1'b0;
            clear_start = 1'b0;
            len++;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset_n     = 1'b0;
        addressM    = 16'h6000;
        outM        = 16'h0000;
        writeM      = 1'b0;
        kbd_strobe  = 1'b0;
        kbd_code    = 16'h0000;
        disp_addr   = 13'h0000;
        clear_start = 1'b0;
        step();
        sb_push("rst_busy", K_BUSY, 16'h0000);
        sb_push("rst_disp", K_DISP, 16'h0000);
        sb_push("rst_kbd",  K_INM,  16'h0000);
        step();
        reset_n = 1'b1;
        step();

        // RAM write then read, boundary word, unmapped writes
        cpu_write(16'h0005, 16'h1234);
        sb_push("ram_rd_after_wr", K_INM, 16'h1234);
        step();
        cpu_write(16'h3FFF, 16'hCAFE);
        sb_push("ram_last_word", K_INM, 16'hCAFE);
        step();
        cpu_write(16'h0001, 16'h0101);
        cpu_write(16'h6001, 16'hBEEF);
        sb_push("unmapped_6001_rd", K_INM, 16'h0000);
        step();
        cpu_write(16'h8000, 16'hBEEF);
        sb_push("unmapped_8000_rd", K_INM, 16'h0000);
        step();
        addressM = 16'h0001;
        sb_push("ram_no_alias_side_effect", K_INM, 16'h0101);
        step();

        // KBD register
        kbd_strobe = 1'b1;
        kbd_code   = 16'h0041;
        step();
        kbd_strobe = 1'b0;
        kbd_code   = 16'h0099;
        addressM   = 16'h6000;
        sb_push("kbd_load", K_INM, 16'h0041);
        step();
        sb_push("kbd_hold", K_INM, 16'h0041);
        step();
        cpu_write(16'h6000, 16'hFFFF);
        sb_push("kbd_cpu_wr_ignored", K_INM, 16'h0041);
        step();
        kbd_strobe = 1'b1;
        kbd_code   = 16'h0000;
        step();
        sb_push("kbd_release", K_INM, 16'h0000);
        kbd_code   = 16'h0041;
        step();
        kbd_strobe = 1'b0;
        sb_push("kbd_reload", K_INM, 16'h0041);
        step();

        // Display port: read-before-write on a collision, then new data
        cpu_write(16'h4010, 16'h1111);
        disp_addr = 13'h0010;
        cpu_write(16'h4010, 16'hAAAA);
        sb_push("disp_rbw_old", K_DISP, 16'h1111);
        step();
        sb_push("disp_new", K_DISP, 16'hAAAA);
        sb_push("scr_cpu_rd", K_INM, 16'hAAAA);
        step();
        cpu_write(16'h5FFF, 16'h7777);
        disp_addr = 13'h1FFF;
        sb_push("scr_last_word", K_INM, 16'h7777);
        step();
        sb_push("disp_last_word", K_DISP, 16'h7777);
        step();

        // Full clear with no SCREEN contention
        fill_screen(16'hFFFF);
        run_clear(-1, len);
        check("clear_len", 32'(len), 32'd8192);
        sb_push("busy_low_after_clear", K_BUSY, 16'h0000);
        step();
        scan_screen(0, 8191, 16'h0000, "cleared_word");
        addressM = 16'h0100;
        sb_push("ram_wr_during_clear", K_INM, 16'h4242);
        step();

        // Clear with one stalled cycle from a CPU SCREEN write
        fill_screen(16'hFFFF);
        run_clear(100, len);
        check("clear_len_stalled", 32'(len), 32'd8193);
        scan_screen(0, 0, 16'h5555, "stall_cpu_word0");
        scan_screen(1, 8191, 16'h0000, "stall_cleared_word");

        // Reset in the middle of a clear
        fill_screen(16'hFFFF);
        disp_addr   = 13'h1000;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 50; i++) step();
        reset_n  = 1'b0;
        addressM = 16'h6000;
        sb_push("busy_async_reset", K_BUSY, 16'h0000);
        sb_push("disp_async_reset", K_DISP, 16'h0000);
        sb_push("kbd_async_reset", K_INM, 16'h0000);
        step();
        reset_n = 1'b1;
        cpu_write(16'h0007, 16'h0777);
        sb_push("first_edge_after_reset", K_INM, 16'h0777);
        step();
        sb_push("busy_idle_after_reset", K_BUSY, 16'h0000);
        scan_screen(0, 49, 16'h0000, "abort_cleared_word");
        scan_screen(50, 8191, 16'hFFFF, "abort_kept_word");
        addressM = 16'h0005;
        sb_push("ram_kept_over_reset", K_INM, 16'h1234);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
